// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared constants and types for the pipelined carry-select add/subtract unit.
//   CSA_WIDTH / CSA_SPLIT : operand width and the bit index where stage 2 starts
//   SEG_LO / SEG_W        : carry-select segment boundaries (3/4/5/6/7/7 bits)
//   OP_ADD / OP_SUB       : encoding of the op input
//   s1_t                  : everything stage 1 hands to stage 2
//   selectUpper()         : carry-select chain over the three upper segments
// ---------------------------------------------------------------------------
package csa_pkg;

    localparam int CSA_WIDTH = 32;
    localparam int CSA_SPLIT = 12;
    localparam int UPPER_W   = CSA_WIDTH - CSA_SPLIT;

    localparam int SEG_LO [6] = '{0, 3, 7, 12, 18, 25};
    localparam int SEG_W  [6] = '{3, 4, 5, 6, 7, 7};

    // Offsets of the upper segments inside the packed upper candidate words
    localparam int U0_LO = SEG_LO[3] - CSA_SPLIT;
    localparam int U1_LO = SEG_LO[4] - CSA_SPLIT;
    localparam int U2_LO = SEG_LO[5] - CSA_SPLIT;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Stage-1 result: resolved low half plus both candidates of each upper
    // segment. sum0/c0 assume a segment carry-in of 0, sum1/c1 a carry-in of 1.
    typedef struct packed {
        logic [UPPER_W-1:0]   sum0;
        logic [UPPER_W-1:0]   sum1;
        logic [2:0]           c0;
        logic [2:0]           c1;
        logic [CSA_SPLIT-1:0] low;
        logic                 c12;
        logic                 op;
        logic                 a31;
        logic                 be31;
    } s1_t;

    // Walks the select chain: c12 picks segment 0, its carry picks segment 1,
    // and so on. Returns {c32, upper result bits}.
    function automatic logic [UPPER_W:0] selectUpper(input s1_t s);
        logic [UPPER_W-1:0] u;
        logic               c;
        u = '0;
        c = s.c12;
        u[U0_LO +: SEG_W[3]] = c ? s.sum1[U0_LO +: SEG_W[3]] : s.sum0[U0_LO +: SEG_W[3]];
        c = c ? s.c1[0] : s.c0[0];
        u[U1_LO +: SEG_W[4]] = c ? s.sum1[U1_LO +: SEG_W[4]] : s.sum0[U1_LO +: SEG_W[4]];
        c = c ? s.c1[1] : s.c0[1];
        u[U2_LO +: SEG_W[5]] = c ? s.sum1[U2_LO +: SEG_W[5]] : s.sum0[U2_LO +: SEG_W[5]];
        c = c ? s.c1[2] : s.c0[2];
        return {c, u};
    endfunction

endpackage

// File: rtl/csa_sub_pipe_if.sv
// ---------------------------------------------------------------------------
// csa_sub_pipe_if
// Operand/result handshake bundle of csa_sub_pipe.
//   in_valid/in_ready   : operand beat handshake (a, b, op)
//   out_valid/out_ready : result beat handshake (d, bo, ovf, zero, neg)
// slave  = the arithmetic unit's view, master = the issuing/consuming side.
// ---------------------------------------------------------------------------
interface csa_sub_pipe_if;
    import csa_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [CSA_WIDTH-1:0] a;
    logic [CSA_WIDTH-1:0] b;
    logic                 op;
    logic                 out_valid;
    logic                 out_ready;
    logic [CSA_WIDTH-1:0] d;
    logic                 bo;
    logic                 ovf;
    logic                 zero;
    logic                 neg;

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, d, bo, ovf, zero, neg
    );

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, d, bo, ovf, zero, neg
    );

endinterface

// File: rtl/csa_seg_dual.sv
// ---------------------------------------------------------------------------
// csa_seg_dual
// One carry-select segment: produces the W-bit sum and carry for both
// possible carry-ins so the real carry only has to pick one later.
//   i_x, i_y        : segment addends
//   o_sum0, o_c0    : result for carry-in 0
//   o_sum1, o_c1    : result for carry-in 1
// ---------------------------------------------------------------------------
module csa_seg_dual #(
    parameter int W = 6
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic [W-1:0] o_sum0,
    output logic         o_c0,
    output logic [W-1:0] o_sum1,
    output logic         o_c1
);

    logic [W:0] w_v;
    logic [W:0] w_bec;

    rca_n #(.N(W)) u_rca (
        .i_x   (i_x),
        .i_y   (i_y),
        .i_cin (1'b0),
        .o_s   (o_sum0),
        .o_cout(o_c0)
    );

    assign w_v = {o_c0, o_sum0};

    // Binary-to-excess-one converter: the carry-in-1 result is the carry-in-0
    // result plus one. x+y never exceeds 2^(W+1)-2, so the increment fits in
    // W+1 bits and its top bit is exactly the carry-in-1 carry out.
    always_comb begin : p_bec
        logic run;
        run   = 1'b1;
        w_bec = '0;
        for (int i = 0; i <= W; i++) begin
            w_bec[i] = w_v[i] ^ run;
            run      = run & w_v[i];
        end
    end

    assign o_sum1 = w_bec[W-1:0];
    assign o_c1   = w_bec[W];

endmodule

// File: rtl/rca_n.sv
// ---------------------------------------------------------------------------
// rca_n
// N-bit ripple-carry adder.
//   i_x, i_y : addends
//   i_cin    : carry in
//   o_s      : sum
//   o_cout   : carry out
// ---------------------------------------------------------------------------
module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic         i_cin,
    output logic [N-1:0] o_s,
    output logic         o_cout
);

    // Plain full-adder chain; the carry lives in a block-local variable so
    // the ripple stays a single combinational process.
    always_comb begin : p_ripple
        logic carry;
        carry = i_cin;
        o_s   = '0;
        for (int i = 0; i < N; i++) begin
            o_s[i] = i_x[i] ^ i_y[i] ^ carry;
            carry  = (i_x[i] & i_y[i]) | (carry & (i_x[i] ^ i_y[i]));
        end
        o_cout = carry;
    end

endmodule

// File: rtl/csa_sub_pipe.sv
// ---------------------------------------------------------------------------
// csa_sub_pipe
// Two-stage pipelined 32-bit carry-select add/subtract (d = a - b when op=1,
// d = a + b when op=0) with valid/ready on both sides.
//   clk, rst : clock and synchronous active-high reset
//   bus      : csa_sub_pipe_if.slave
//              in_valid/in_ready/a/b/op          operand side
//              out_valid/out_ready/d/bo/ovf/zero/neg result side
// Stage 1 resolves bits [SPLIT-1:0] and builds both candidates for each upper
// segment; stage 2 runs the carry-select chain and forms the flags.
// ---------------------------------------------------------------------------
module csa_sub_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SPLIT = CSA_SPLIT
) (
    input  logic          clk,
    input  logic          rst,
    csa_sub_pipe_if.slave bus
);

    logic             w_adv1;
    logic             w_adv2;
    logic             w_accept;
    logic             w_cin;
    logic [WIDTH-1:0] w_be;

    logic [SEG_W[0]-1:0] w_lo0;
    logic [SEG_W[1]-1:0] w_lo1;
    logic [SEG_W[2]-1:0] w_lo2;
    logic                w_c3;
    logic                w_c7;
    logic                w_c12;
    logic [SPLIT-1:0]    w_low;

    logic [SEG_W[3]-1:0] w_u0Sum0, w_u0Sum1;
    logic [SEG_W[4]-1:0] w_u1Sum0, w_u1Sum1;
    logic [SEG_W[5]-1:0] w_u2Sum0, w_u2Sum1;
    logic                w_u0C0, w_u0C1;
    logic                w_u1C0, w_u1C1;
    logic                w_u2C0, w_u2C1;

    s1_t  w_s1Next;
    s1_t  r_s1;
    logic r_s1Valid;

    logic [UPPER_W:0] w_upper;
    logic             w_c32;
    logic [WIDTH-1:0] w_d;

    logic             r_outValid;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    // Handshake: in_ready depends combinationally on out_ready so a full
    // pipe can still take a beat in the same cycle the result drains.
    assign w_adv2       = !r_outValid || bus.out_ready;
    assign w_adv1       = !r_s1Valid || w_adv2;
    assign bus.in_ready = w_adv1 && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;

    // Subtraction is a + ~b + 1: invert b and use op as the carry-in.
    assign w_cin = (bus.op == OP_SUB);
    assign w_be  = w_cin ? ~bus.b : bus.b;

    rca_n #(.N(SEG_W[0])) u_lo0 (
        .i_x   (bus.a[SEG_LO[0] +: SEG_W[0]]),
        .i_y   (w_be[SEG_LO[0] +: SEG_W[0]]),
        .i_cin (w_cin),
        .o_s   (w_lo0),
        .o_cout(w_c3)
    );

    rca_n #(.N(SEG_W[1])) u_lo1 (
        .i_x   (bus.a[SEG_LO[1] +: SEG_W[1]]),
        .i_y   (w_be[SEG_LO[1] +: SEG_W[1]]),
        .i_cin (w_c3),
        .o_s   (w_lo1),
        .o_cout(w_c7)
    );

    rca_n #(.N(SEG_W[2])) u_lo2 (
        .i_x   (bus.a[SEG_LO[2] +: SEG_W[2]]),
        .i_y   (w_be[SEG_LO[2] +: SEG_W[2]]),
        .i_cin (w_c7),
        .o_s   (w_lo2),
        .o_cout(w_c12)
    );

    assign w_low = {w_lo2, w_lo1, w_lo0};

    csa_seg_dual #(.W(SEG_W[3])) u_up0 (
        .i_x   (bus.a[SEG_LO[3] +: SEG_W[3]]),
        .i_y   (w_be[SEG_LO[3] +: SEG_W[3]]),
        .o_sum0(w_u0Sum0),
        .o_c0  (w_u0C0),
        .o_sum1(w_u0Sum1),
        .o_c1  (w_u0C1)
    );

    csa_seg_dual #(.W(SEG_W[4])) u_up1 (
        .i_x   (bus.a[SEG_LO[4] +: SEG_W[4]]),
        .i_y   (w_be[SEG_LO[4] +: SEG_W[4]]),
        .o_sum0(w_u1Sum0),
        .o_c0  (w_u1C0),
        .o_sum1(w_u1Sum1),
        .o_c1  (w_u1C1)
    );

    csa_seg_dual #(.W(SEG_W[5])) u_up2 (
        .i_x   (bus.a[SEG_LO[5] +: SEG_W[5]]),
        .i_y   (w_be[SEG_LO[5] +: SEG_W[5]]),
        .o_sum0(w_u2Sum0),
        .o_c0  (w_u2C0),
        .o_sum1(w_u2Sum1),
        .o_c1  (w_u2C1)
    );

    // Collect everything stage 2 needs into one register word.
    always_comb begin
        w_s1Next      = '0;
        w_s1Next.sum0 = {w_u2Sum0, w_u1Sum0, w_u0Sum0};
        w_s1Next.sum1 = {w_u2Sum1, w_u1Sum1, w_u0Sum1};
        w_s1Next.c0   = {w_u2C0, w_u1C0, w_u0C0};
        w_s1Next.c1   = {w_u2C1, w_u1C1, w_u0C1};
        w_s1Next.low  = w_low;
        w_s1Next.c12  = w_c12;
        w_s1Next.op   = bus.op;
        w_s1Next.a31  = bus.a[WIDTH-1];
        w_s1Next.be31 = w_be[WIDTH-1];
    end

    // Stage 1 loads only on accept; an empty or draining slot goes invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid <= 1'b0;
            r_s1      <= '0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1      <= w_s1Next;
        end else if (w_adv1) begin
            r_s1Valid <= 1'b0;
        end
    end

    assign w_upper = selectUpper(r_s1);
    assign w_c32   = w_upper[UPPER_W];
    assign w_d     = {w_upper[UPPER_W-1:0], r_s1.low};

    // Stage 2: result and flags only move on a transfer, so they stay
    // frozen while the consumer stalls. For subtraction the borrow is the
    // inverted carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_d        <= '0;
            r_bo       <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
        end else if (w_adv2 && r_s1Valid) begin
            r_outValid <= 1'b1;
            r_d        <= w_d;
            r_bo       <= (r_s1.op == OP_ADD) ? w_c32 : ~w_c32;
            r_ovf      <= (r_s1.a31 == r_s1.be31) && (w_d[WIDTH-1] != r_s1.a31);
            r_zero     <= ~|w_d;
            r_neg      <= w_d[WIDTH-1];
        end else if (w_adv2) begin
            r_outValid <= 1'b0;
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.d         = r_d;
    assign bus.bo        = r_bo;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
    assign bus.neg       = r_neg;

endmodule

// File: tb/tb_csa_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_csa_sub_pipe
// Scoreboard bench for csa_sub_pipe: operands are issued through
// applyStimulus, which queues the expected result from an arithmetic
// reference model; a separate monitor pops and compares every delivered
// result, and also watches stall stability and in_ready.
// ---------------------------------------------------------------------------
module tb_csa_sub_pipe;
    import csa_pkg::*;

    typedef struct packed {
        logic [31:0] d;
        logic        bo;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        res_t r;
        int   cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   readyMode = 0;
    int   readyCnt = 0;
    int   latencyStrict = 0;
    sb_t  sbq[$];

    logic held;
    res_t heldVal;
    res_t cur;

    csa_sub_pipe_if bus ();

    csa_sub_pipe dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: plain wide integer arithmetic. Borrow/carry come from the
    // unsigned result, overflow from whether the signed result fits 32 bits.
    function automatic res_t refModel(input logic [31:0] a, input logic [31:0] b, input logic op);
        longint ua, ub, sa, sb, full, sres;
        res_t   r;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_SUB) begin
            full = ua - ub;
            sres = sa - sb;
            r.bo = (ua < ub);
        end else begin
            full = ua + ub;
            sres = sa + sb;
            r.bo = (full > 64'sd4294967295);
        end
        r.d    = full[31:0];
        r.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        r.zero = (r.d == 32'd0);
        r.neg  = r.d[31];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Issues one beat (entered and left at posedge+1) and queues its
    // expected result once it is accepted. in_valid is left high so
    // consecutive calls form a back-to-back stream.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op);
        bit acc;
        int accCyc;
        int waitCnt;
        acc = 1'b0;
        accCyc = 0;
        waitCnt = 0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.op = op;
        while (!acc && waitCnt < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            accCyc = cycle;
            @(posedge clk);
            #1;
            waitCnt++;
        end
        if (acc) begin
            sbq.push_back('{r: refModel(a, b, op), cyc: accCyc});
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.op = 1'($urandom_range(0, 1));
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        readyMode = 0;
        bus.in_valid = 1'b0;
        while (!(sbq.size() == 0 && !bus.out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_pending", 64'(sbq.size()), 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Consumer side: out_ready pattern selected by readyMode
    // (0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready).
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (readyCnt % 3 == 0);
                    readyCnt++;
                end
                2: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: at each negedge checks in_ready against pipeline occupancy
    // (beats accepted but not yet delivered), holds stalled outputs steady,
    // and pops/compares every result that transfers at the next edge.
    initial begin
        held = 1'b0;
        forever begin
            @(negedge clk);
            cur = {bus.d, bus.bo, bus.ovf, bus.zero, bus.neg};
            if (rst) begin
                held = 1'b0;
                checkOutput("in_ready_in_reset", 64'(bus.in_ready), 64'd0);
            end else begin
                checkOutput("in_ready", 64'(bus.in_ready), 64'(!(sbq.size() >= 2 && !bus.out_ready)));
                if (held) begin
                    checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
                    checkOutput("stall_hold", 64'(cur), 64'(heldVal));
                end
                held = 1'b0;
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (sbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_beat: got d=%h, expected no beat", bus.d);
                        end else begin
                            sb_t e;
                            e = sbq.pop_front();
                            checkOutput("result", 64'(cur), 64'(e.r));
                            if (latencyStrict != 0)
                                checkOutput("latency", 64'(cycle - e.cyc), 64'd2);
                        end
                    end else begin
                        held = 1'b1;
                        heldVal = cur;
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = OP_ADD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", 64'({bus.out_valid, bus.d, bus.bo, bus.ovf, bus.zero, bus.neg}), 64'd0);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] directed corner cases");
        latencyStrict = 1;
        readyMode = 0;
        idle(2);
        applyStimulus(32'h0000_0005, 32'h0000_0003, OP_SUB); idle(2);
        applyStimulus(32'h0000_0000, 32'h0000_0001, OP_SUB); idle(2);
        applyStimulus(32'h8000_0000, 32'h0000_0001, OP_SUB); idle(2);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD); idle(2);
        applyStimulus(32'h1234_5678, 32'h1234_5678, OP_SUB); idle(2);
        applyStimulus(32'h0000_1000, 32'h0000_0001, OP_SUB);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
        applyStimulus(32'h8000_0000, 32'h8000_0000, OP_ADD);
        applyStimulus(32'h0003_F000, 32'h0000_1000, OP_ADD);
        drain();

        $display("[TB] back-to-back stream with out_ready 1,0,0");
        latencyStrict = 0;
        readyCnt = 0;
        readyMode = 1;
        for (int i = 0; i < 8; i++)
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)));
        drain();

        $display("[TB] reset with both stages full");
        readyMode = 3;
        idle(2);
        applyStimulus(32'h0000_0010, 32'h0000_0001, OP_SUB);
        applyStimulus(32'h0000_0020, 32'h0000_0002, OP_SUB);
        idle(2);
        @(negedge clk);
        checkOutput("full_out_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        sbq.delete();
        @(negedge clk);
        checkOutput("rst_flush", 64'({bus.out_valid, bus.d}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        readyMode = 0;
        latencyStrict = 1;
        idle(1);
        applyStimulus(32'hDEAD_BEEF, 32'h0BAD_F00D, OP_SUB);
        drain();

        $display("[TB] random stream under random backpressure");
        latencyStrict = 0;
        readyMode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle(1);
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
